pipe_elastic_stage: RTL and testbench
=====================================

Name: pipe_elastic_stage

Overview:
Parametrised elastic pipeline fence. It replaces the fixed stall/enable/flush pipe registers between core stages with a DEPTH-entry valid/ready buffer of W-bit payloads. Upstream stalls arise from `in_ready`, not from external stall wires, and a synchronous flush clears all in-flight entries. It is instantiated between IF/ID, ID/EX, EX/MEM and MEM/WB of the next-generation RV32 pipeline.

Parameters:
W, 32, payload width in bits (≥1)
DEPTH, 2, buffer entries (≥1); DEPTH=1 is a plain registered fence with bubble fill
CNT_W, $clog2(DEPTH+1), occupancy counter width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
flush  in  1  synchronous kill of all held entries (branch/jump redirect)
in_valid  in  1  upstream payload valid
in_ready  out  1  stage can accept this cycle
in_data  in  W  upstream payload
out_valid  out  1  head entry valid
out_ready  in  1  downstream accepts head
out_data  out  W  head entry payload
count  out  CNT_W  current occupancy, 0..DEPTH

Behaviour:
- Reset (rst=0, async): rd_ptr=0, wr_ptr=0, count=0, out_valid=0, in_ready=1. `out_data` is don't-care but reads the storage at index 0. Storage is not cleared.
- Transfers:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - Both take effect at the rising edge.
- in_ready = (count != DEPTH). It is registered-derived, with no combinational path from `out_ready`. A full buffer therefore does not accept in the same cycle as a pop.
- out_valid = (count != 0). out_data = mem[rd_ptr]. Both depend only on state.
- Latency: a payload pushed at edge N is visible at `out_data` after edge N (one cycle). Throughput is 1/cycle sustained when DEPTH ≥ 2.
- DEPTH=1: the throughput ceiling is 1 transfer per 2 cycles under continuous backpressure release. This is accepted.
- Pointers wrap from DEPTH-1 to 0. Non-power-of-2 DEPTH must wrap by compare, not bit truncation.
- count update:
  - push only: +1
  - pop only: −1
  - push and pop together: unchanged, both pointers advance
  - neither: unchanged
- Full (count=DEPTH): push is impossible; a pop decrements.
- Empty (count=0): pop is impossible; a push increments.
- Empty with push and pop asserted: only the push happens, since out_valid=0.
- flush=1 at an edge:
  - count←0, rd_ptr←0, wr_ptr←0.
  - Any simultaneous push or pop is discarded; the pop is treated as not having occurred.
  - out_valid=0 on the next cycle.
  - flush has priority over everything except reset.
- Reset asserted mid-operation: all held entries are lost immediately (async) and outputs go to reset values. Deassertion is assumed synchronised externally.
- `in_valid` may drop without handshake. The stage does not require AXI-style valid stability.

Optional Feature:
Macro PIPE_BYPASS_EN.
- Defined: when count=0 and out_ready=1, an incoming payload passes combinationally and is not stored.
  - out_valid = in_valid | (count≠0).
  - out_data = (count==0) ? in_data : mem[rd_ptr].
  - in_ready = (count≠DEPTH) | out_ready.
  - This gives zero-latency forwarding; push and pop on an empty stage leave count=0.
  - flush still forces out_valid=0 and in_ready=0 in its cycle.
- Undefined: behaviour exactly as above, with 1-cycle latency and no combinational in→out path.

Decomposition:
- Shared package `pipe_pkg`:
  - clog2-based CNT_W helper function.
  - Stage payload widths as constants: IF_ID_W=64, ID_EX_W=160, EX_MEM_W=107, MEM_WB_W=71.
  - Pointer-increment-with-wrap function.
- One sub-module, `pipe_elastic_mem`: DEPTH×W register array with write port (we, waddr, wdata) and async read port (raddr → rdata). It keeps storage separate from the control counter/pointer logic.

Test Plan:
1. Reset, then idle → count=0, out_valid=0, in_ready=1. W=32, DEPTH=2.
2. Push 0xA, 0xB on consecutive cycles with out_ready=0 → count=2, in_ready=0, out_data=0xA. A third push of 0xC is not accepted. Then out_ready=1 for 2 cycles → outputs 0xA then 0xB, count=0.
3. Sustained streaming 0x1..0x10 with in_valid=out_ready=1 (DEPTH=2) → 16 outputs in order, one per cycle after 1-cycle latency, count stays 1.
4. DEPTH=3 with random valid/ready for 1000 cycles → output sequence equals input sequence (scoreboard). count is never >3. Pointers wrap correctly through 2→0.
5. Hold 2 entries, assert flush together with in_valid=1 (0x55) and out_ready=1 → next cycle count=0, out_valid=0. 0x55 never appears and the popped entry is not counted as delivered.
6. Drive rst=0 mid-stream between clock edges with count=2 → out_valid=0 and count=0 immediately, before the next edge. After release, the first push of 0x77 appears one cycle later. With PIPE_BYPASS_EN, 0x77 appears the same cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline fences of the RV32 core.
// Contents:
//   - per-stage payload widths
//   - width helpers for the occupancy counter and the buffer pointers
//   - pointer increment with wrap, valid for any depth including
//     non-power-of-two depths
package pipe_pkg;

    localparam int IF_ID_W  = 64;
    localparam int ID_EX_W  = 160;
    localparam int EX_MEM_W = 107;
    localparam int MEM_WB_W = 71;

    // The counter has to hold every value from 0 to depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // A single-entry buffer still needs a one-bit pointer for a legal port.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Wrapping is done by compare, so non-power-of-two depths never
    // index past the last entry.
    function automatic int unsigned ptr_next(input int unsigned ptr,
                                             input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/pipe_elastic_stage_if.sv
// Valid/ready payload channel used on both sides of an elastic stage.
// Signals:
//   valid - producer has a payload this cycle
//   ready - consumer can take it this cycle
//   data  - W-bit payload
// Modports:
//   master - producer side (drives valid/data, observes ready)
//   slave  - consumer side (drives ready, observes valid/data)
interface pipe_elastic_stage_if #(
    parameter int W = 32
);
    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_elastic_mem.sv
// Storage array for an elastic stage: DEPTH entries of W bits.
// Ports:
//   clk   - rising-edge clock
//   we    - write enable
//   waddr - write index
//   wdata - write payload
//   raddr - read index (asynchronous read)
//   rdata - payload at raddr
// The array is never cleared; occupancy tracking lives in the control logic.
module pipe_elastic_mem #(
    parameter int W     = 32,
    parameter int DEPTH = 2,
    parameter int AW    = 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    // Single write port; the control logic only ever addresses valid slots.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pipe_elastic_stage.sv
// Elastic pipeline fence: a DEPTH-entry valid/ready buffer of W-bit payloads
// placed between core stages. Upstream stalls come from up.ready; flush
// synchronously discards everything in flight.
// Ports:
//   clk   - rising-edge clock
//   rst   - asynchronous active-low reset
//   flush - synchronous kill of all held entries
//   up    - upstream channel (slave): valid/data in, ready out
//   dn    - downstream channel (master): valid/data out, ready in
//   count - current occupancy, 0..DEPTH
// Build option PIPE_BYPASS_EN: an empty stage forwards the incoming payload
// combinationally when downstream is ready, without storing it.
module pipe_elastic_stage
    import pipe_pkg::*;
#(
    parameter int W     = 32,
    parameter int DEPTH = 2,
    localparam int CNT_W = cnt_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    pipe_elastic_stage_if.slave   up,
    pipe_elastic_stage_if.master  dn,
    output logic [CNT_W-1:0]      count
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count_q;
    logic [W-1:0]     head;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;
    logic             store;
    logic             advance;

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);

`ifdef PIPE_BYPASS_EN
    // Empty stage passes the upstream payload straight through; flush
    // blanks both handshakes for its cycle.
    assign up.ready = ~flush & (~full | dn.ready);
    assign dn.valid = ~flush & (up.valid | ~empty);
    assign dn.data  = empty ? up.data : head;
`else
    // Both handshake outputs come only from registered occupancy, so there
    // is no combinational path from dn.ready to up.ready.
    assign up.ready = ~full;
    assign dn.valid = ~empty;
    assign dn.data  = head;
`endif

    assign push = up.valid & up.ready;
    assign pop  = dn.valid & dn.ready;

    // A push that is consumed in the same cycle from an empty stage is a
    // pass-through and never lands in storage (only reachable with bypass).
    assign store   = push & ~(pop & empty);
    assign advance = pop & ~empty;

    assign count = count_q;

    pipe_elastic_mem #(
        .W     (W),
        .DEPTH (DEPTH),
        .AW    (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (store & ~flush),
        .waddr (wr_ptr),
        .wdata (up.data),
        .raddr (rd_ptr),
        .rdata (head)
    );

    // Pointer and occupancy state; flush outranks any same-cycle transfer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (store) begin
                wr_ptr <= PTR_W'(ptr_next(32'(wr_ptr), DEPTH));
            end
            if (advance) begin
                rd_ptr <= PTR_W'(ptr_next(32'(rd_ptr), DEPTH));
            end
            case ({store, advance})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_elastic_stage.sv
// Directed bench for pipe_elastic_stage: a DEPTH=2 instance driven from a
// vector table plus reset/flush sequences, and a DEPTH=3 instance driven
// with random valid/ready against a queue model.
module tb_pipe_elastic_stage;

    logic       clk;
    logic       rst;
    logic       flush2;
    logic       flush3;
    logic [1:0] count2;
    logic [1:0] count3;

    int checks;
    int errors;

    pipe_elastic_stage_if #(.W(32)) up2 ();
    pipe_elastic_stage_if #(.W(32)) dn2 ();
    pipe_elastic_stage_if #(.W(32)) up3 ();
    pipe_elastic_stage_if #(.W(32)) dn3 ();

    pipe_elastic_stage #(.W(32), .DEPTH(2)) dut2 (
        .clk   (clk),
        .rst   (rst),
        .flush (flush2),
        .up    (up2),
        .dn    (dn2),
        .count (count2)
    );

    pipe_elastic_stage #(.W(32), .DEPTH(3)) dut3 (
        .clk   (clk),
        .rst   (rst),
        .flush (flush3),
        .up    (up3),
        .dn    (dn3),
        .count (count3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [31:0] din;
        logic        ordy;
        logic        fl;
        logic        ov;
        logic        ir;
        logic [31:0] dout;
        int          cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic addVec(input logic iv, input logic [31:0] din,
                          input logic ordy, input logic fl,
                          input logic ov, input logic ir,
                          input logic [31:0] dout, input int cnt);
        vec_t v;
        v.iv = iv; v.din = din; v.ordy = ordy; v.fl = fl;
        v.ov = ov; v.ir = ir; v.dout = dout; v.cnt = cnt;
        vecs.push_back(v);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        up2.valid  = v.iv;
        up2.data   = v.din;
        dn2.ready  = v.ordy;
        flush2     = v.fl;
    endtask

    initial begin
        int q[$];
        logic [31:0] next_data;
        logic do_push;
        logic do_pop;

        checks    = 0;
        errors    = 0;
        rst       = 1'b0;
        flush2    = 1'b0;
        flush3    = 1'b0;
        up2.valid = 1'b0;
        up2.data  = '0;
        dn2.ready = 1'b0;
        up3.valid = 1'b0;
        up3.data  = '0;
        dn3.ready = 1'b0;

        // Test 2: fill, refused third push, drain.
        addVec(1, 32'hA, 0, 0, 1, 1, 32'hA, 1);
        addVec(1, 32'hB, 0, 0, 1, 0, 32'hA, 2);
        addVec(1, 32'hC, 0, 0, 1, 0, 32'hA, 2);
        addVec(0, 32'h0, 1, 0, 1, 1, 32'hB, 1);
        addVec(0, 32'h0, 1, 0, 0, 1, 32'h0, 0);
        // Test 3: sustained streaming, occupancy holds at one.
        for (int i = 1; i <= 16; i++) begin
            addVec(1, 32'(i), 1, 0, 1, 1, 32'(i), 1);
        end
        addVec(0, 32'h0, 1, 0, 0, 1, 32'h0, 0);
        // Test 5: two held entries with pointers moved, then flush with
        // a simultaneous push and pop.
        addVec(1, 32'h21, 0, 0, 1, 1, 32'h21, 1);
        addVec(1, 32'h22, 0, 0, 1, 0, 32'h21, 2);
        addVec(0, 32'h0,  1, 0, 1, 1, 32'h22, 1);
        addVec(1, 32'h23, 0, 0, 1, 0, 32'h22, 2);
        addVec(1, 32'h55, 1, 1, 0, 1, 32'h0,  0);
        addVec(0, 32'h0,  1, 0, 0, 1, 32'h0,  0);
        addVec(1, 32'h66, 0, 0, 1, 1, 32'h66, 1);
        addVec(0, 32'h0,  1, 0, 0, 1, 32'h0,  0);

        // Test 1: reset state, during and after reset.
        #2;
        checkOutput("rst_count", 32'(count2), 32'd0);
        checkOutput("rst_out_valid", 32'(dn2.valid), 32'd0);
        checkOutput("rst_in_ready", 32'(up2.ready), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("idle_count", 32'(count2), 32'd0);
        checkOutput("idle_out_valid", 32'(dn2.valid), 32'd0);
        checkOutput("idle_in_ready", 32'(up2.ready), 32'd1);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            @(posedge clk);
            @(negedge clk);
            checkOutput($sformatf("vec%0d_out_valid", i), 32'(dn2.valid), 32'(vecs[i].ov));
            checkOutput($sformatf("vec%0d_in_ready", i), 32'(up2.ready), 32'(vecs[i].ir));
            checkOutput($sformatf("vec%0d_count", i), 32'(count2), 32'(vecs[i].cnt));
            if (vecs[i].ov) begin
                checkOutput($sformatf("vec%0d_out_data", i), dn2.data, vecs[i].dout);
            end
        end
        up2.valid = 1'b0;
        dn2.ready = 1'b0;
        flush2    = 1'b0;

        // Test 6: asynchronous reset between edges with two entries held.
        up2.valid = 1'b1;
        up2.data  = 32'h31;
        @(posedge clk);
        @(negedge clk);
        up2.data  = 32'h32;
        @(posedge clk);
        @(negedge clk);
        up2.valid = 1'b0;
        checkOutput("prerst_count", 32'(count2), 32'd2);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("midrst_count", 32'(count2), 32'd0);
        checkOutput("midrst_out_valid", 32'(dn2.valid), 32'd0);
        checkOutput("midrst_in_ready", 32'(up2.ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        up2.valid = 1'b1;
        up2.data  = 32'h77;
        #1;
        checkOutput("post_rst_pre_edge_valid", 32'(dn2.valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        up2.valid = 1'b0;
        checkOutput("post_rst_out_valid", 32'(dn2.valid), 32'd1);
        checkOutput("post_rst_out_data", dn2.data, 32'h77);
        checkOutput("post_rst_count", 32'(count2), 32'd1);

        // Test 4: DEPTH=3 random valid/ready against an in-order queue.
        next_data = 32'h100;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            checkOutput($sformatf("rnd%0d_count", c), 32'(count3), 32'(q.size()));
            checkOutput($sformatf("rnd%0d_out_valid", c), 32'(dn3.valid), 32'(q.size() != 0));
            checkOutput($sformatf("rnd%0d_in_ready", c), 32'(up3.ready), 32'(q.size() != 3));
            if (q.size() != 0) begin
                checkOutput($sformatf("rnd%0d_out_data", c), dn3.data, q[0]);
            end
            up3.valid = 1'($urandom_range(0, 1));
            up3.data  = next_data;
            dn3.ready = 1'($urandom_range(0, 1));
            do_push = up3.valid && (q.size() < 3);
            do_pop  = dn3.ready && (q.size() > 0);
            @(posedge clk);
            if (do_pop) begin
                void'(q.pop_front());
            end
            if (do_push) begin
                q.push_back(int'(next_data));
                next_data = next_data + 1;
            end
        end
        up3.valid = 1'b0;
        dn3.ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
